// File: rtl/lc3_seq_alu.sv
// lc3_seq_alu: multi-cycle LC-3 style ALU.
//   ADD/AND/NOT/PASS complete in one cycle. SHL/SHR/SRA shift one bit per
//   clock. MUL is a WIDTH-step shift-add. Start is accepted only while idle.
//   Result and NZP are registered together and change only on a Done edge.
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   Start                 request pulse, sampled when Busy=0
//   ALUK                  operation select
//   SR2MUX, Imm           B operand select / immediate (sign-extended)
//   SR1_Data, SR2_Data    A and B operands
//   Result, NZP           registered result and its {N,Z,P} flags
//   Busy                  iterative operation in progress
//   Done                  one-cycle pulse, Result/NZP valid
module lc3_seq_alu #(
  parameter int WIDTH   = 16,
  parameter int IMM_W   = 5,
  parameter int SHAMT_W = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [2:0]         ALUK,
  input  logic               SR2MUX,
  input  logic [IMM_W-1:0]   Imm,
  input  logic [WIDTH-1:0]   SR1_Data,
  input  logic [WIDTH-1:0]   SR2_Data,
  output logic [WIDTH-1:0]   Result,
  output logic               Busy,
  output logic               Done,
  output logic [2:0]         NZP
);

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   b_in;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic               is_shift;
  logic               is_mul;
  logic               go_iter;
  logic [WIDTH-1:0]   single_res;

  // Iteration working registers: acc holds the shifting value or the
  // product accumulator; Result stays untouched until the final edge.
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [1:0]         shift_kind;
  logic [SHAMT_W-1:0] cnt;

  logic [WIDTH-1:0]   shift_nxt;
  logic [WIDTH-1:0]   mul_nxt;
  logic               last;
  logic               res_we;
  logic [WIDTH-1:0]   res_val;

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                 input logic [1:0]       kind);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    case (kind)
      2'b00:   return v << 1;
      2'b01:   return v >> 1;
      default: return $unsigned(sv >>> 1);
    endcase
  endfunction

  function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] v);
    if (v == '0)          return 3'b010;
    else if (v[WIDTH-1])  return 3'b100;
    else                  return 3'b001;
  endfunction

  assign b_in     = SR2MUX ? {{(WIDTH-IMM_W){Imm[IMM_W-1]}}, Imm} : SR2_Data;
  assign shamt    = b_in[SHAMT_W-1:0];
  assign Busy     = (state != IDLE);
  assign accept   = Start && (state == IDLE);
  assign is_mul   = (ALUK == 3'b111);
  assign is_shift = ALUK[2] && !is_mul;
  // A zero-distance shift is finished immediately and behaves as PASS.
  assign go_iter  = is_mul || (is_shift && (shamt != '0));

  always_comb begin
    single_res = SR1_Data;
    case (ALUK)
      3'b000:  single_res = SR1_Data + b_in;
      3'b001:  single_res = SR1_Data & b_in;
      3'b010:  single_res = ~SR1_Data;
      default: single_res = SR1_Data;
    endcase
  end

  assign shift_nxt = shift_one(acc, shift_kind);
  assign mul_nxt   = acc + (mplier[0] ? mcand : '0);
  assign last      = (cnt == '0);

  always_comb begin
    state_nxt = state;
    res_we    = 1'b0;
    res_val   = single_res;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mul)       state_nxt = MUL;
          else if (go_iter) state_nxt = SHIFT;
          else              res_we    = 1'b1;
        end
      end
      SHIFT: begin
        res_val = shift_nxt;
        if (last) begin
          res_we    = 1'b1;
          state_nxt = IDLE;
        end
      end
      MUL: begin
        res_val = mul_nxt;
        if (last) begin
          res_we    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      Done   <= 1'b0;
      Result <= '0;
      NZP    <= 3'b010;
    end else begin
      state <= state_nxt;
      Done  <= res_we;
      if (res_we) begin
        Result <= res_val;
        NZP    <= nzp_of(res_val);
      end
    end
  end

  // Operand capture on the accepting edge, then one step per edge.
  always_ff @(posedge Clk) begin
    case (state)
      IDLE: begin
        if (accept) begin
          acc        <= is_mul ? '0 : SR1_Data;
          mcand      <= SR1_Data;
          mplier     <= b_in;
          shift_kind <= ALUK[1:0];
          cnt        <= is_mul ? SHAMT_W'(WIDTH - 1) : shamt - 1'b1;
        end
      end
      SHIFT: begin
        acc <= shift_nxt;
        cnt <= cnt - 1'b1;
      end
      MUL: begin
        acc    <= mul_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_seq_alu.sv
module tb_lc3_seq_alu;

  logic        Clk = 1'b0;
  logic        Reset, Start, SR2MUX;
  logic [2:0]  ALUK;
  logic [4:0]  Imm;
  logic [15:0] SR1_Data, SR2_Data;
  logic [15:0] Result;
  logic        Busy, Done;
  logic [2:0]  NZP;

  int vecs  = 0;
  int fails = 0;

  lc3_seq_alu #(.WIDTH(16), .IMM_W(5), .SHAMT_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ALUK(ALUK), .SR2MUX(SR2MUX),
    .Imm(Imm), .SR1_Data(SR1_Data), .SR2_Data(SR2_Data),
    .Result(Result), .Busy(Busy), .Done(Done), .NZP(NZP)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble inputs after acceptance, wait for Done (bounded),
  // check latency, Busy while waiting, result, flags and single Done pulse.
  task automatic run_op(input string tag, input logic [2:0] aluk, input logic sr2mux,
                        input logic [4:0] imm, input logic [15:0] a, input logic [15:0] b,
                        input int lat, input logic [15:0] exp_res, input logic [2:0] exp_nzp);
    int n;
    ALUK = aluk; SR2MUX = sr2mux; Imm = imm; SR1_Data = a; SR2_Data = b;
    Start = 1'b1;
    step();
    Start = 1'b0;
    SR1_Data = 16'hDEAD; SR2_Data = 16'hBEEF; Imm = 5'h0A; SR2MUX = ~sr2mux;
    n = 1;
    while (Done !== 1'b1 && n < 40) begin
      chk({tag, "_busy"}, Busy, 1);
      step();
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_res"}, Result, exp_res);
    chk({tag, "_nzp"}, NZP, exp_nzp);
    chk({tag, "_busy_done"}, Busy, 0);
    step();
    chk({tag, "_done_pulse"}, Done, 0);
  endtask

  initial begin
    int dcnt;
    int n;
    Reset = 1'b1; Start = 1'b0; ALUK = 3'b000; SR2MUX = 1'b0; Imm = '0;
    SR1_Data = '0; SR2_Data = '0;
    step(); step();
    Reset = 1'b0;
    chk("rst_res", Result, 16'h0000);
    chk("rst_nzp", NZP, 3'b010);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);

    // ADD with negative immediate: 0x20 + (-16)
    run_op("add_imm", 3'b000, 1'b1, 5'b10000, 16'h0020, 16'h1234, 1, 16'h0010, 3'b001);
    run_op("and_imm", 3'b001, 1'b1, 5'b01111, 16'hFFF3, 16'h0000, 1, 16'h0003, 3'b001);
    run_op("not",     3'b010, 1'b0, 5'b00000, 16'h0000, 16'h0000, 1, 16'hFFFF, 3'b100);
    run_op("pass0",   3'b011, 1'b0, 5'b00000, 16'h0000, 16'h5555, 1, 16'h0000, 3'b010);
    run_op("add_wrap",3'b000, 1'b0, 5'b00000, 16'hFFFF, 16'h0002, 1, 16'h0001, 3'b001);
    run_op("mul3x5",  3'b111, 1'b0, 5'b00000, 16'h0003, 16'h0005, 17, 16'h000F, 3'b001);
    run_op("mulff",   3'b111, 1'b0, 5'b00000, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 3'b001);
    run_op("mulimm",  3'b111, 1'b1, 5'b11111, 16'h0003, 16'h0000, 17, 16'hFFFD, 3'b100);
    run_op("sra4",    3'b110, 1'b0, 5'b00000, 16'h8000, 16'h0004, 5, 16'hF800, 3'b100);
    run_op("shr4",    3'b101, 1'b0, 5'b00000, 16'h8000, 16'h0004, 5, 16'h0800, 3'b001);
    run_op("sra0",    3'b110, 1'b0, 5'b00000, 16'h8000, 16'h0000, 1, 16'h8000, 3'b100);
    run_op("shl15",   3'b100, 1'b0, 5'b00000, 16'h0001, 16'h00FF, 16, 16'h8000, 3'b100);
    run_op("shl3imm", 3'b100, 1'b1, 5'b00011, 16'h1001, 16'h0000, 4, 16'h8008, 3'b100);

    // Start pulsed during MUL must be ignored
    ALUK = 3'b111; SR2MUX = 1'b0; SR1_Data = 16'h0007; SR2_Data = 16'h0009;
    Start = 1'b1;
    step();
    Start = 1'b0;
    n = 1;
    repeat (4) begin step(); n++; end
    ALUK = 3'b000; SR1_Data = 16'h0100; SR2_Data = 16'h0001; Start = 1'b1;
    step(); n++;
    Start = 1'b0;
    dcnt = 0;
    while (Done !== 1'b1 && n < 40) begin step(); n++; end
    chk("mulign_lat", n, 17);
    chk("mulign_res", Result, 16'h003F);
    chk("mulign_nzp", NZP, 3'b001);
    repeat (5) begin step(); if (Done === 1'b1) dcnt++; end
    chk("mulign_extra_done", dcnt, 0);

    // Start held high across Done: second op accepted in the Done cycle
    ALUK = 3'b100; SR2MUX = 1'b0; SR1_Data = 16'h0001; SR2_Data = 16'h0002;
    Start = 1'b1;
    step();
    chk("b2b_busy1", Busy, 1);
    ALUK = 3'b010; SR1_Data = 16'h00FF;
    step();
    chk("b2b_busy2", Busy, 1);
    chk("b2b_nodone2", Done, 0);
    step();
    chk("b2b_done1", Done, 1);
    chk("b2b_res1", Result, 16'h0004);
    chk("b2b_busy3", Busy, 0);
    step();
    Start = 1'b0;
    chk("b2b_done2", Done, 1);
    chk("b2b_res2", Result, 16'hFF00);
    chk("b2b_nzp2", NZP, 3'b100);
    chk("b2b_busy4", Busy, 0);
    step();
    chk("b2b_end", Done, 0);

    // Reset mid-MUL abandons the operation
    ALUK = 3'b111; SR1_Data = 16'h0003; SR2_Data = 16'h0003; Start = 1'b1;
    step();
    Start = 1'b0;
    repeat (7) step();
    chk("rmul_busy_pre", Busy, 1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("rmul_busy", Busy, 0);
    chk("rmul_done", Done, 0);
    chk("rmul_res", Result, 16'h0000);
    chk("rmul_nzp", NZP, 3'b010);
    dcnt = 0;
    repeat (20) begin step(); if (Done === 1'b1) dcnt++; end
    chk("rmul_no_done", dcnt, 0);
    chk("rmul_res_hold", Result, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
